clk_gate_ctrl: RTL and testbench

Idle-detect controller that produces the `enable` input of the clock-gate cell for one functional unit. It watches unit activity and a software permission bit. After a programmable number of idle cycles it drops `enable` to stop the unit clock. On a wake request it restores `enable` and holds off `ready` until a fixed wake latency has elapsed. It runs on the free-running `clk`, never on the gated clock it controls.

---
 rtl/clk_gate_ctrl.sv | 107 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: idle-detect controller driving the enable pin of one unit's
// clock-gate cell. Runs on the free-running clock, never on the gated one.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   RUN       | clock on, unit ready, watching for idle
//   IDLE_WAIT | clock on, counting down consecutive idle cycles
//   GATED     | clock stopped, waiting for any wake condition
//   WAKE      | clock restarted, holding off ready for the wake latency
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sleep_allow,
  input  logic             busy,
  input  logic             wake_req,
  input  logic             force_on,
  output logic             enable,
  output logic             ready,
  output logic             gated,
  output logic [CNT_W-1:0] gate_count
);

  // Counters only ever hold PARAM-1 down to 0.
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_IDLE_WAIT = 2'd1,
    S_GATED     = 2'd2,
    S_WAKE      = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;
  logic          idle;

  // Any activity, wake request, debug override or missing permission aborts idling.
  assign idle = sleep_allow & ~busy & ~wake_req & ~force_on;

  // Sequencer with registered outputs; enable only moves on clk edges so the
  // gate cell's latch never sees a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RUN;
      idle_cnt   <= '0;
      wake_cnt   <= '0;
      enable     <= 1'b1;
      ready      <= 1'b1;
      gated      <= 1'b0;
      gate_count <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (idle) begin
            state    <= S_IDLE_WAIT;
            idle_cnt <= IW'(IDLE_CYCLES - 1);
          end
        end
        S_IDLE_WAIT: begin
          // Abort wins over an expiring count: no gating, no count bump.
          if (!idle) begin
            state <= S_RUN;
          end else if (idle_cnt == '0) begin
            state  <= S_GATED;
            enable <= 1'b0;
            ready  <= 1'b0;
            gated  <= 1'b1;
            if (gate_count != {CNT_W{1'b1}})
              gate_count <= gate_count + 1'b1;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end
        S_GATED: begin
          if (!idle) begin
            state    <= S_WAKE;
            wake_cnt <= WW'(WAKE_CYCLES - 1);
            enable   <= 1'b1;
            gated    <= 1'b0;
          end
        end
        S_WAKE: begin
          // Inputs ignored until the clock has been stable long enough.
          if (wake_cnt == '0) begin
            state <= S_RUN;
            ready <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_RUN;
          enable <= 1'b1;
          ready  <= 1'b1;
          gated  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a streak-counting behavioural model.
module tb_clk_gate_ctrl;

  localparam int IDLE_CYCLES = 4;
  localparam int WAKE_CYCLES = 2;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sleep_allow = 1'b1;
  logic             busy = 1'b0;
  logic             wake_req = 1'b0;
  logic             force_on = 1'b0;
  logic             enable, ready, gated;
  logic [CNT_W-1:0] gate_count;

  int n_vec  = 0;
  int n_fail = 0;

  clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sleep_allow(sleep_allow),
    .busy       (busy),
    .wake_req   (wake_req),
    .force_on   (force_on),
    .enable     (enable),
    .ready      (ready),
    .gated      (gated),
    .gate_count (gate_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: gating happens once IDLE_CYCLES+1 consecutive idle
  // samples are seen with the clock running; wake needs WAKE_CYCLES edges.
  int m_streak = 0;
  int m_wake_left = 0;
  bit m_gated = 1'b0;
  int m_count = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_streak = 0; m_wake_left = 0; m_gated = 1'b0; m_count = 0;
    end else begin
      bit idle_s;
      idle_s = sleep_allow && !busy && !wake_req && !force_on;
      if (m_gated) begin
        if (!idle_s) begin
          m_gated = 1'b0;
          m_wake_left = WAKE_CYCLES;
        end
      end else if (m_wake_left > 0) begin
        m_wake_left--;
      end else if (idle_s) begin
        m_streak++;
        if (m_streak == IDLE_CYCLES + 1) begin
          m_gated = 1'b1;
          m_streak = 0;
          if (m_count < CNT_MAX) m_count++;
        end
      end else begin
        m_streak = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("enable", int'(enable), int'(!m_gated));
      check("ready", int'(ready), int'(!m_gated && m_wake_left == 0));
      check("gated", int'(gated), int'(m_gated));
      check("gate_count", int'(gate_count), m_count);
    end
  end

  task automatic set_idle();
    sleep_allow = 1'b1; busy = 1'b0; wake_req = 1'b0; force_on = 1'b0;
  endtask

  // Counts negedges until gated rises; bounded.
  task automatic wait_gated(input string name, output int k);
    k = 0;
    while (gated !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (gated !== 1'b1) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wake_pulse();
    wake_req = 1'b1;
    @(negedge clk);
    wake_req = 1'b0;
    check("wake_enable_N", int'(enable), 1);
    check("wake_ready_N", int'(ready), 0);
    busy = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    check("wake_ready_N1", int'(ready), 0);
    @(negedge clk);
    check("wake_ready_N2", int'(ready), 1);
  endtask

  initial begin
    int k;
    set_idle();
    repeat (2) @(negedge clk);
    check("rst_enable", int'(enable), 1);
    check("rst_ready", int'(ready), 1);
    check("rst_gated", int'(gated), 0);
    check("rst_count", int'(gate_count), 0);
    rst = 1'b0;

    // Idle from the first edge: five idle samples then gated.
    wait_gated("t1", k);
    check("t1_edges", k, IDLE_CYCLES + 1);
    check("t1_count", int'(gate_count), 1);
    check("t1_ready", int'(ready), 0);

    // One-cycle wake pulse; busy toggled during WAKE is ignored.
    wake_pulse();

    // Abort after three idle samples; gating 5 edges after the abort edge.
    repeat (3) @(negedge clk);
    busy = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    check("t2_enable", int'(enable), 1);
    wait_gated("t2", k);
    check("t2_edges", k, IDLE_CYCLES + 1);
    check("t2_count", int'(gate_count), 2);

    // force_on while gated wakes normally, then holds the clock for 100 cycles.
    force_on = 1'b1;
    @(negedge clk);
    check("t4_wake_enable", int'(enable), 1);
    repeat (100) @(negedge clk);
    check("t4_force_enable", int'(enable), 1);
    force_on = 1'b0; sleep_allow = 1'b0;
    repeat (100) @(negedge clk);
    check("t4_sa_enable", int'(enable), 1);
    check("t4_count", int'(gate_count), 2);

    // Abort coincident with the final idle sample: no gating.
    set_idle();
    repeat (IDLE_CYCLES) @(negedge clk);
    busy = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    check("t5_gated", int'(gated), 0);
    check("t5_count", int'(gate_count), 2);

    // Saturation: five more gate/wake rounds, counter sticks at all-ones.
    for (int r = 0; r < 5; r++) begin
      wait_gated("t6", k);
      wake_pulse();
    end
    check("t6_sat", int'(gate_count), CNT_MAX);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sleep_allow = ($urandom_range(0, 99) < 92);
      busy        = ($urandom_range(0, 99) < 8);
      wake_req    = ($urandom_range(0, 99) < 4);
      force_on    = ($urandom_range(0, 99) < 2);
    end

    // Asynchronous reset in the middle of GATED.
    @(negedge clk);
    set_idle();
    wait_gated("t6r", k);
    rst = 1'b1;
    #1;
    check("arst_enable", int'(enable), 1);
    check("arst_ready", int'(ready), 1);
    check("arst_gated", int'(gated), 0);
    check("arst_count", int'(gate_count), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
